// File: rtl/generic_bus_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | generic_bus_if : requester <-> memory responder bus signals                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic        ren;
  logic        wen;
  logic [31:0] rdata;
  logic        busy;

  modport generic_bus (
    input  addr, wdata, byte_en, ren, wen,
    output rdata, busy
  );

  modport slave (
    input  addr, wdata, byte_en, ren, wen,
    output rdata, busy
  );

  modport master (
    output addr, wdata, byte_en, ren, wen,
    input  rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/generic_bus_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | generic_bus_mem_responder : fixed-latency word memory behind generic_bus_if |
// | Optional error output enabled by macro GENBUS_RESP_ERR_EN.                  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module generic_bus_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  generic_bus_if.generic_bus bus_if
`ifdef GENBUS_RESP_ERR_EN
  ,
  output logic               error
`endif
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_C      = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q,   cnt_d;
  logic [31:0]    addr_q,  addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     be_q,    be_d;
  logic           ren_q,   ren_d;
  logic           wen_q,   wen_d;

  logic [31:0]    mem_q [DEPTH_WORDS];

  logic [32:0]    w_off;
  logic           w_in_range;
  logic           w_err;
  logic [IDX_W-1:0] w_idx;

  // 33-bit subtraction: bit 32 set means the address lies below BASE_ADDR.
  assign w_off      = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign w_in_range = !w_off[32] && (w_off[31:0] < SPAN_BYTES);
  assign w_idx      = w_off[IDX_W+1:2];

`ifdef GENBUS_RESP_ERR_EN
  assign w_err = !w_in_range || (addr_q[1:0] != 2'b00);
  assign error = (state_q == RESP) && w_err;
`else
  assign w_err = !w_in_range;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    case (state_q)
      IDLE: begin
        if (bus_if.ren || bus_if.wen) begin
          addr_d  = bus_if.addr;
          wdata_d = bus_if.wdata;
          be_d    = bus_if.byte_en;
          ren_d   = bus_if.ren;
          wen_d   = bus_if.wen;
          cnt_d   = LAT_C;
          state_d = (LAT_C != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // A requester that changes its request while waiting withdraws it.
        if ((bus_if.ren != ren_q) || (bus_if.wen != wen_q) || (bus_if.addr != addr_q)) begin
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus_if.busy  = (state_q != RESP);
  assign bus_if.rdata = ((state_q == RESP) && !wen_q && !w_err) ? mem_q[w_idx] : 32'h0;

  // Storage has no reset; a reset during RESP forces IDLE so the write is dropped.
  always_ff @(posedge CLK) begin
    if ((state_q == RESP) && wen_q && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_generic_bus_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_generic_bus_mem_responder : vector table, corner sequences, random model |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_generic_bus_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

`ifdef GENBUS_RESP_ERR_EN
  localparam logic [31:0] MIS_RD_EXP = 32'h0;
  localparam logic [31:0] MIS_WR_EXP = 32'hDEAD_BEAA;
`else
  localparam logic [31:0] MIS_RD_EXP = 32'hDEAD_BEAA;
  localparam logic [31:0] MIS_WR_EXP = 32'hFFFF_FFFF;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  generic_bus_if bus_a();
  generic_bus_if bus_b();

`ifdef GENBUS_RESP_ERR_EN
  logic err_a, err_b;
`endif

  generic_bus_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_a (
    .CLK    (clk),
    .nRST   (rst_n),
    .bus_if (bus_a)
`ifdef GENBUS_RESP_ERR_EN
    ,
    .error  (err_a)
`endif
  );

  generic_bus_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_b (
    .CLK    (clk),
    .nRST   (rst_n),
    .bus_if (bus_b)
`ifdef GENBUS_RESP_ERR_EN
    ,
    .error  (err_b)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    if (sel) begin
      bus_b.ren = ren; bus_b.wen = wen; bus_b.addr = addr; bus_b.wdata = wdata; bus_b.byte_en = be;
    end else begin
      bus_a.ren = ren; bus_a.wen = wen; bus_a.addr = addr; bus_a.wdata = wdata; bus_a.byte_en = be;
    end
  endtask

  function automatic logic [31:0] busy_of(input bit sel);
    return sel ? 32'(bus_b.busy) : 32'(bus_a.busy);
  endfunction

  function automatic logic [31:0] rdata_of(input bit sel);
    return sel ? bus_b.rdata : bus_a.rdata;
  endfunction

  function automatic bit exp_err(input logic [31:0] a);
    bit oor;
    oor = (a < BASE) || ((a - BASE) >= 32'(4 * DEPTH));
`ifdef GENBUS_RESP_ERR_EN
    return oor || (a[1:0] != 2'b00);
`else
    return oor;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: hold request through WAIT, release it during RESP.
  task automatic txn(input string name, input bit sel, input int lat,
                     input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp_rd);
    drive(sel, ren, wen, addr, wdata, be);
    for (int k = 1; k <= lat + 1; k++) begin
      tick();
      if (k <= lat) begin
        chk({name, " busy wait"}, busy_of(sel), 32'd1);
        chk({name, " rdata wait"}, rdata_of(sel), 32'd0);
      end else begin
        chk({name, " busy resp"}, busy_of(sel), 32'd0);
        chk({name, " rdata resp"}, rdata_of(sel), exp_rd);
`ifdef GENBUS_RESP_ERR_EN
        chk({name, " error resp"}, sel ? 32'(err_b) : 32'(err_a), 32'(exp_err(addr)));
`endif
      end
    end
    drive(sel, 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
    tick();
    chk({name, " busy idle"}, busy_of(sel), 32'd1);
  endtask

  initial begin
    logic        r_ren, r_wen;
    logic [31:0] r_addr, r_wdata, r_exp;
    logic [3:0]  r_be;
    int          idx;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) tick();
    chk("reset busy a",  busy_of(1'b0),  32'd1);
    chk("reset rdata a", rdata_of(1'b0), 32'd0);
    chk("reset busy b",  busy_of(1'b1),  32'd1);
    chk("reset rdata b", rdata_of(1'b1), 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- directed vector table on the LATENCY=2 responder ----
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0010, 32'h0000_00AA, 4'h1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0014, 32'h1122_3344, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0014, 32'hAABB_CCDD, 4'hA, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0014, 32'h0,         4'h0, 32'hAA22_CC44});
    vecs.push_back('{1'b1, 1'b1, 32'h8000_0018, 32'hCAFE_F00D, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0018, 32'h0,         4'h0, 32'hCAFE_F00D});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0004, 32'h4444_0004, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0FFC, 32'h5555_AAAA, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h7FFF_FFFC, 32'h8765_4321, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0BAD_F00D});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h5555_AAAA});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0012, 32'h0,         4'h0, MIS_RD_EXP});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0013, 32'hFFFF_FFFF, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0010, 32'h0,         4'h0, MIS_WR_EXP});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0020, 32'h2020_2020, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0024, 32'h2424_2424, 4'hF, 32'h0});
    foreach (vecs[i]) begin
      txn($sformatf("vec%0d", i), 1'b0, 2, vecs[i].ren, vecs[i].wen, vecs[i].addr,
          vecs[i].wdata, vecs[i].be, vecs[i].exp);
    end

    // ---- abort: address changes while waiting ----
    drive(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    tick();
    chk("abort accepted busy", busy_of(1'b0), 32'd1);
    bus_a.addr = 32'h8000_0004;
    tick();
    chk("abort idle busy", busy_of(1'b0), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k < 3) begin
        chk($sformatf("abort rewait%0d busy", k), busy_of(1'b0), 32'd1);
      end else begin
        chk("abort resp busy",  busy_of(1'b0),  32'd0);
        chk("abort resp rdata", rdata_of(1'b0), 32'h4444_0004);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();

    // ---- reset during WAIT of a write ----
    drive(1'b0, 1'b0, 1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst wait busy",  busy_of(1'b0),  32'd1);
    chk("rst wait rdata", rdata_of(1'b0), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();
    txn("rst wait readback", 1'b0, 2, 1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h2020_2020);

    // ---- reset during RESP of a read, then of a write ----
    drive(1'b0, 1'b1, 1'b0, 32'h8000_0014, 32'h0, 4'h0);
    repeat (3) tick();
    chk("rst resp pre busy",  busy_of(1'b0),  32'd0);
    chk("rst resp pre rdata", rdata_of(1'b0), 32'hAA22_CC44);
    rst_n = 1'b0;
    #1;
    chk("rst resp busy",  busy_of(1'b0),  32'd1);
    chk("rst resp rdata", rdata_of(1'b0), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h8000_0024, 32'hFFFF_FFFF, 4'hF);
    repeat (3) tick();
    chk("rst wresp pre busy", busy_of(1'b0), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst wresp busy", busy_of(1'b0), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();
    txn("rst wresp readback", 1'b0, 2, 1'b1, 1'b0, 32'h8000_0024, 32'h0, 4'h0, 32'h2424_2424);

    // ---- LATENCY=0 responder: single transactions, then back-to-back ----
    txn("l0 write", 1'b1, 0, 1'b0, 1'b1, 32'h8000_0008, 32'h0B0B_0B0B, 4'hF, 32'h0);
    txn("l0 read",  1'b1, 0, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h0B0B_0B0B);
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("l0 b2b busy%0d", k), busy_of(1'b1), (k % 2 == 1) ? 32'd0 : 32'd1);
      chk($sformatf("l0 b2b rdata%0d", k), rdata_of(1'b1), (k % 2 == 1) ? 32'h0B0B_0B0B : 32'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();

    // ---- randomized traffic against a word-array model ----
    for (int i = 0; i < 16; i++) begin
      r_wdata = $urandom;
      r_addr  = BASE + 32'h100 + 32'(4 * i);
      txn($sformatf("rinit%0d", i), 1'b0, 2, 1'b0, 1'b1, r_addr, r_wdata, 4'hF, 32'h0);
      model[64 + i] = r_wdata;
    end
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0, 3:    begin r_ren = 1'b1; r_wen = 1'b0; end
        1:       begin r_ren = 1'b0; r_wen = 1'b1; end
        default: begin r_ren = 1'b1; r_wen = 1'b1; end
      endcase
      if ($urandom_range(0, 7) == 0) begin
        r_addr = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 8))
                                             : BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
      end else begin
        r_addr = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      end
      r_wdata = $urandom;
      r_be    = 4'($urandom);
      idx     = int'((r_addr - BASE) >> 2);
      r_exp   = (!r_wen && !exp_err(r_addr)) ? model[idx] : 32'h0;
      txn($sformatf("rand%0d", n), 1'b0, 2, r_ren, r_wen, r_addr, r_wdata, r_be, r_exp);
      if (r_wen && !exp_err(r_addr)) begin
        for (int b = 0; b < 4; b++) begin
          if (r_be[b]) model[idx][8*b +: 8] = r_wdata[8*b +: 8];
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
